// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the front pipeline. Works out, each
//   cycle, whether the IF/ID and ID/EX stage registers hold or bubble, and
//   issues a one-cycle PC redirect to fetch after a taken branch/jump or a
//   trap. It handles load-use hazards, data-memory waits (with a sticky
//   watchdog), branch/jump redirects and trap redirects.
//
//   Priority per cycle: trap_en > bj_en > dmem_busy > load-use > !imem_ready.
//
//   Optional feature macro: PIPE_HAZARD_PERF_EN
//     defined   -> 32-bit wrapping stall/flush cycle counters on perf_*.
//     undefined -> no counter flops, perf_* tied to 0.
//
// Parameters
//   XLEN          width of PC / redirect target
//   FLUSH_CYCLES  cycles clear_* are held after a redirect, trigger included (1..15)
//   WDOG_CYCLES   dmem wait cycles before wdog_err sets (1..65535)
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   id_rs1/id_rs2            ID-stage source registers
//   id_rs_valid              [0] rs1 used, [1] rs2 used
//   ex_is_load, ex_rd        EX-stage load flag and destination register
//   bj_en, bj_pc             taken branch/jump and its target
//   trap_en, trap_pc         trap/exception/mret and its target
//   imem_ready               fetch data valid this cycle
//   dmem_busy                data memory still working; hold the pipeline
//   stall_if                 hold PC
//   stall_if_id/clear_if_id  hold / bubble the IF/ID register
//   stall_id_ex/clear_id_ex  hold / bubble the ID/EX register
//   redirect_en/redirect_pc  one-cycle PC load request and target
//   wdog_err                 sticky dmem watchdog error
//   perf_stall/perf_flush    performance counters (see macro above)
//   dbg_state                current FSM state (0 RUN, 1 MEM_WAIT, 2 FLUSH)
//
// Handshake: there is no valid/ready pair here; redirect_en is a single-cycle
// request that fetch must accept unconditionally in the cycle it is high.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_CYCLES  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [1:0]      id_rs_valid,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            bj_en,
  input  logic [XLEN-1:0] bj_pc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            imem_ready,
  input  logic            dmem_busy,
  output logic            stall_if,
  output logic            stall_if_id,
  output logic            clear_if_id,
  output logic            stall_id_ex,
  output logic            clear_id_ex,
  output logic            redirect_en,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wdog_err,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_e;

  // Cycles still to spend in FLUSH after the trigger cycle.
  localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [15:0] WDOG_LIM    = 16'(WDOG_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       wait_inc;
  logic              redir_en_q, redir_en_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              wdog_q, wdog_d;
  logic              load_use;
  logic              take_redirect;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs_valid[0] && (id_rs1 == ex_rd)) ||
                     (id_rs_valid[1] && (id_rs2 == ex_rd)));

  // A branch/jump seen while flushing belongs to the wrong path.
  assign take_redirect = trap_en || (bj_en && (state_q != S_FLUSH));

  // Saturating so a very long wait never wraps back under the limit.
  assign wait_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : (wait_cnt_q + 16'd1);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    redir_en_d  = 1'b0;
    redir_pc_d  = redir_pc_q;
    wdog_d      = wdog_q;
    stall_if    = 1'b0;
    stall_if_id = 1'b0;
    clear_if_id = 1'b0;
    stall_id_ex = 1'b0;
    clear_id_ex = 1'b0;

    if (rst) begin
      // Bubble both stage registers while in reset; the flops reset on the edge.
      clear_if_id = 1'b1;
      clear_id_ex = 1'b1;
    end else if (take_redirect) begin
      clear_if_id = 1'b1;
      clear_id_ex = 1'b1;
      redir_en_d  = 1'b1;
      redir_pc_d  = trap_en ? trap_pc : bj_pc;
      if (MULTI_FLUSH) begin
        state_d     = S_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d     = S_RUN;
        flush_cnt_d = '0;
      end
    end else if (state_q == S_FLUSH) begin
      // dmem_busy is not honoured here: clears win over stalls while flushing.
      clear_if_id = 1'b1;
      clear_id_ex = 1'b1;
      if (flush_cnt_q <= 4'd1) begin
        state_d     = S_RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q - 4'd1;
      end
    end else if (dmem_busy) begin
      stall_if    = 1'b1;
      stall_if_id = 1'b1;
      stall_id_ex = 1'b1;
      state_d     = S_MEM_WAIT;
      wait_cnt_d  = wait_inc;
      if (wait_inc >= WDOG_LIM) begin
        wdog_d = 1'b1;
      end
    end else begin
      // RUN, or the MEM_WAIT exit cycle, in which the pipeline advances as in RUN.
      state_d = S_RUN;
      if (load_use) begin
        stall_if    = 1'b1;
        stall_if_id = 1'b1;
        clear_id_ex = 1'b1;
      end else if (!imem_ready) begin
        stall_if    = 1'b1;
        clear_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      redir_en_q  <= 1'b0;
      redir_pc_q  <= '0;
      wdog_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      redir_en_q  <= redir_en_d;
      redir_pc_q  <= redir_pc_d;
      wdog_q      <= wdog_d;
    end
  end

  // Gated by rst so a redirect pending from the cycle before reset is dropped.
  assign redirect_en = redir_en_q && !rst;
  assign redirect_pc = redir_pc_q;
  assign wdog_err    = wdog_q;
  assign dbg_state   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_if || stall_if_id || stall_id_ex) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (clear_if_id) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int XLEN = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic [1:0]      id_rs_valid;
  logic            ex_is_load, bj_en, trap_en, imem_ready, dmem_busy;
  logic [XLEN-1:0] bj_pc, trap_pc;

  // DUT a: FLUSH_CYCLES=3, WDOG_CYCLES=3
  logic            stall_if, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex;
  logic            redirect_en, wdog_err;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_stall, perf_flush;
  logic [1:0]      dbg_state;

  // DUT b: default parameters (FLUSH_CYCLES=1, WDOG_CYCLES=255)
  logic            b_stall_if, b_stall_if_id, b_clear_if_id, b_stall_id_ex, b_clear_id_ex;
  logic            b_redirect_en, b_wdog_err;
  logic [XLEN-1:0] b_redirect_pc;
  logic [31:0]     b_perf_stall, b_perf_flush;
  logic [1:0]      b_dbg_state;

  pipe_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(3), .WDOG_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_valid(id_rs_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .bj_en(bj_en), .bj_pc(bj_pc),
    .trap_en(trap_en), .trap_pc(trap_pc), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_if_id(stall_if_id), .clear_if_id(clear_if_id),
    .stall_id_ex(stall_id_ex), .clear_id_ex(clear_id_ex), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .wdog_err(wdog_err), .perf_stall(perf_stall),
    .perf_flush(perf_flush), .dbg_state(dbg_state)
  );

  pipe_hazard_ctrl #(.XLEN(XLEN)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_valid(id_rs_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .bj_en(bj_en), .bj_pc(bj_pc),
    .trap_en(trap_en), .trap_pc(trap_pc), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .stall_if(b_stall_if), .stall_if_id(b_stall_if_id), .clear_if_id(b_clear_if_id),
    .stall_id_ex(b_stall_id_ex), .clear_id_ex(b_clear_id_ex), .redirect_en(b_redirect_en),
    .redirect_pc(b_redirect_pc), .wdog_err(b_wdog_err), .perf_stall(b_perf_stall),
    .perf_flush(b_perf_flush), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Control vector: {stall_if, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex, redirect_en, wdog_err}
  localparam int W = 7;
  localparam logic [W-1:0] E_IDLE   = 7'b0000000;
  localparam logic [W-1:0] E_CLR    = 7'b0010100;
  localparam logic [W-1:0] E_CLR_RE = 7'b0010110;
  localparam logic [W-1:0] E_LU     = 7'b1100100;
  localparam logic [W-1:0] E_FM     = 7'b1010000;
  localparam logic [W-1:0] E_MW     = 7'b1101000;

  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] pc_q[$];
  logic            exp_wd;
  int              checks;
  int              failures;

  typedef struct {
    logic            rst;
    logic            ld;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      rv;
    logic            bj;
    logic [XLEN-1:0] bjpc;
    logic            trap;
    logic [XLEN-1:0] tpc;
    logic            imem;
    logic            busy;
  } stim_t;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.ld = 1'b0; s.rd = '0; s.rs1 = '0; s.rs2 = '0; s.rv = '0;
    s.bj = 1'b0; s.bjpc = '0; s.trap = 1'b0; s.tpc = '0; s.imem = 1'b1; s.busy = 1'b0;
    return s;
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of stimulus and queues the control vector expected for it.
  // wdog_err is a register: its expectation for this cycle is the value before the edge.
  task automatic drive(input stim_t s, input logic [W-1:0] e);
    rst = s.rst; ex_is_load = s.ld; ex_rd = s.rd; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs_valid = s.rv; bj_en = s.bj; bj_pc = s.bjpc; trap_en = s.trap; trap_pc = s.tpc;
    imem_ready = s.imem; dmem_busy = s.busy;
    exp_q.push_back(e | {6'b0, exp_wd});
    if (s.rst) exp_wd = 1'b0;
  endtask

  function automatic logic [W-1:0] got_a();
    return {stall_if, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex, redirect_en, wdog_err};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t s;
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      s = idle();
      s.rst = (i < 2);
      s.bj = 1'b1; s.bjpc = 64'h1234;   // ignored during reset
      if (i == 2) s.bj = 1'b0;
      drive(s, (i < 2) ? E_CLR : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e) begin
        failures++; $display("FAIL reset cyc=%0d got=%b exp=%b", i, got_a(), e);
      end
      if (i > 0) begin
        checks++;
        if (redirect_pc !== '0 || dbg_state !== 2'd0) begin
          failures++; $display("FAIL reset_regs cyc=%0d pc=%h st=%0d exp pc=0 st=0", i, redirect_pc, dbg_state);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [W-1:0] e;
    logic haz;
    int mode;
    for (int i = 0; i < 10; i++) begin
      s = idle();
      s.ld = 1'b1;
      mode = (i == 0) ? 0 : int'($urandom_range(0, 4));
      s.rd = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      case (mode)
        0: begin s.rs1 = s.rd; s.rs2 = s.rd ^ 5'd1; s.rv = 2'b01; end
        1: begin s.rs1 = s.rd ^ 5'd2; s.rs2 = s.rd; s.rv = 2'b10; end
        2: begin s.rs1 = s.rd; s.rs2 = s.rd ^ 5'd1; s.rv = 2'b10; end
        3: begin s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.rv = 2'b11; end
        default: begin s.ld = 1'b0; s.rs1 = s.rd; s.rs2 = s.rd; s.rv = 2'b11; end
      endcase
      haz = s.ld && (s.rd != 0) && ((s.rv[0] && s.rs1 == s.rd) || (s.rv[1] && s.rs2 == s.rd));
      for (int c = 0; c < 2; c++) begin
        if (c == 1) s.ld = 1'b0;   // load advances: hazard gone
        drive(s, (c == 0 && haz) ? E_LU : E_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (got_a() !== e) begin
          failures++; $display("FAIL load_use it=%0d mode=%0d cyc=%0d got=%b exp=%b", i, mode, c, got_a(), e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_fetch_miss();
    stim_t s;
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      s = idle();
      s.imem = 1'b0;
      if (i == 1) begin   // load-use outranks a fetch miss
        s.ld = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.rv = 2'b10;
      end
      if (i == 2) s.imem = 1'b1;
      drive(s, (i == 0) ? E_FM : (i == 1) ? E_LU : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e) begin
        failures++; $display("FAIL fetch_miss cyc=%0d got=%b exp=%b", i, got_a(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t s;
    logic [W-1:0] e;
    logic [XLEN-1:0] pe;
    logic [W-1:0] tab [5] = '{E_CLR, E_CLR_RE, E_CLR, E_IDLE, E_IDLE};
    for (int i = 0; i < 5; i++) begin
      s = idle();
      if (i == 0) begin
        s.bj = 1'b1; s.bjpc = 64'h8000_0100; s.busy = 1'b1;   // redirect outranks dmem_busy
        pc_q.push_back(64'h8000_0100);
      end
      drive(s, tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e) begin
        failures++; $display("FAIL redirect cyc=%0d got=%b exp=%b", i, got_a(), e);
      end
      if (e[1]) begin
        pe = pc_q.pop_front();
        checks++;
        if (redirect_pc !== pe) begin
          failures++; $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, pe);
        end
      end
      if (i < 2) begin
        checks++;
        if ({b_clear_if_id, b_clear_id_ex, b_redirect_en} !== ((i == 0) ? 3'b110 : 3'b001)) begin
          failures++; $display("FAIL redirect_flush1 cyc=%0d got=%b exp=%b", i,
                               {b_clear_if_id, b_clear_id_ex, b_redirect_en}, (i == 0) ? 3'b110 : 3'b001);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap_bj();
    stim_t s;
    logic [W-1:0] e;
    logic [XLEN-1:0] pe;
    // 0: trap+bj; 1,2: bj in FLUSH ignored; 3..5: flush tail / idle;
    // 6: bj; 7: trap in FLUSH restarts; 8,9: held; 10: RUN
    logic [W-1:0] tab [11] = '{E_CLR, E_CLR_RE, E_CLR, E_IDLE, E_IDLE, E_IDLE,
                               E_CLR, E_CLR_RE, E_CLR_RE, E_CLR, E_IDLE};
    for (int i = 0; i < 11; i++) begin
      s = idle();
      case (i)
        0: begin s.trap = 1'b1; s.tpc = 64'h8000_0000; s.bj = 1'b1; s.bjpc = 64'h8000_0400;
                 pc_q.push_back(64'h8000_0000); end
        1, 2: begin s.bj = 1'b1; s.bjpc = 64'h8000_0800; end
        6: begin s.bj = 1'b1; s.bjpc = 64'h0000_2000; pc_q.push_back(64'h0000_2000); end
        7: begin s.trap = 1'b1; s.tpc = 64'h0000_0040; pc_q.push_back(64'h0000_0040); end
        default: ;
      endcase
      drive(s, tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e) begin
        failures++; $display("FAIL trap_bj cyc=%0d got=%b exp=%b", i, got_a(), e);
      end
      if (e[1]) begin
        pe = pc_q.pop_front();
        checks++;
        if (redirect_pc !== pe) begin
          failures++; $display("FAIL trap_bj_pc cyc=%0d got=%h exp=%h", i, redirect_pc, pe);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t s;
    logic [W-1:0] e;
    logic [XLEN-1:0] pe;
    int bcnt;
    // 0,1 busy; 2 trap aborts wait; 3,4 flush; 5 idle; 6,7 busy (counter restarted);
    // 8 idle; 9..12 busy with watchdog; 13..15 idle, wdog sticky
    logic [W-1:0] tab [16] = '{E_MW, E_MW, E_CLR, E_CLR_RE, E_CLR, E_IDLE, E_MW, E_MW,
                               E_IDLE, E_MW, E_MW, E_MW, E_MW, E_IDLE, E_IDLE, E_IDLE};
    bcnt = 0;
    for (int i = 0; i < 16; i++) begin
      s = idle();
      s.busy = (i <= 2) || (i == 6) || (i == 7) || (i >= 9 && i <= 12);
      if (i == 2) begin
        s.trap = 1'b1; s.tpc = 64'h0000_0100; pc_q.push_back(64'h0000_0100);
      end
      drive(s, tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e) begin
        failures++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, got_a(), e);
      end
      if (e[1]) begin
        pe = pc_q.pop_front();
        checks++;
        if (redirect_pc !== pe) begin
          failures++; $display("FAIL mem_wait_pc got=%h exp=%h", redirect_pc, pe);
        end
      end
      if (i == 12 || i == 15) begin
        checks++;
        if (b_wdog_err !== 1'b0) begin
          failures++; $display("FAIL wdog_default cyc=%0d got=%b exp=0", i, b_wdog_err);
        end
      end
      @(posedge clk); #1;
      // Watchdog model: counts consecutive busy-stall cycles, cleared on exit or abort.
      if (s.busy && !s.trap) bcnt++;
      else bcnt = 0;
      if (bcnt >= 3) exp_wd = 1'b1;
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t s;
    logic [W-1:0] e;
    // 0: bj; 1,2: rst (flush aborted, no redirect); 3,4: RUN, no redirect
    logic [W-1:0] tab [5] = '{E_CLR, E_CLR, E_CLR, E_IDLE, E_IDLE};
    for (int i = 0; i < 5; i++) begin
      s = idle();
      if (i == 0) begin s.bj = 1'b1; s.bjpc = 64'hdead_0000; end
      if (i == 1 || i == 2) s.rst = 1'b1;
      if (i == 2) begin s.trap = 1'b1; s.tpc = 64'h4; end
      drive(s, tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got_a() !== e || b_redirect_en !== 1'b0 && i > 0) begin
        failures++; $display("FAIL reset_mid_flush cyc=%0d got=%b exp=%b b_re=%b", i, got_a(), e, b_redirect_en);
      end
      if (i >= 2) begin
        checks++;
        if (redirect_pc !== '0 || perf_stall !== 32'd0 || perf_flush !== 32'd0) begin
          failures++; $display("FAIL reset_clears cyc=%0d pc=%h ps=%0d pf=%0d exp 0/0/0", i, redirect_pc, perf_stall, perf_flush);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
    stim_t s;
    logic [31:0] exp_ps, exp_pf;
    for (int i = 0; i < 3; i++) begin
      s = idle();
      if (i == 0) begin s.ld = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9; s.rv = 2'b01; end
      if (i == 1) s.imem = 1'b0;
      drive(s, (i == 0) ? E_LU : (i == 1) ? E_FM : E_IDLE);
      @(negedge clk);
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
`ifdef PIPE_HAZARD_PERF_EN
    exp_ps = 32'd2; exp_pf = 32'd1;
`else
    exp_ps = 32'd0; exp_pf = 32'd0;
`endif
    checks++;
    if (perf_stall !== exp_ps || perf_flush !== exp_pf) begin
      failures++; $display("FAIL perf got=%0d/%0d exp=%0d/%0d", perf_stall, perf_flush, exp_ps, exp_pf);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0; failures = 0; exp_wd = 1'b0;
    rst = 1'b1; ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_rs_valid = '0;
    bj_en = 1'b0; bj_pc = '0; trap_en = 1'b0; trap_pc = '0; imem_ready = 1'b1; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_fetch_miss();
    test_redirect();
    test_trap_bj();
    test_mem_wait();
    test_reset_mid_flush();
    test_perf();
    if (exp_q.size() != 0 || pc_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain exp_left=%0d pc_left=%0d exp 0/0", exp_q.size(), pc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
